sync_fifo: RTL and testbench

- Single-clock, parametrised FIFO for buffering inside one clock domain, where a CDC crossing is not needed.
- Adds the following beyond the dual-clock FIFO:
  - fill-level output
  - programmable almost-full and almost-empty flags
  - sticky overflow and underflow error flags
  - synchronous flush
- Storage is a register array of 2**POINTER entries addressed by binary pointers, with one extra wrap bit.

---
 rtl/sync_fifo.sv | 161 ++++++++++++++++
 tb/tb_sync_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with fill level, programmable almost-full/almost-empty
// flags, sticky overflow/underflow and synchronous flush. Define SYNC_FIFO_FWFT_EN for first-word fall-through.
module sync_fifo #(
    parameter int WIDTH         = 8,
    parameter int POINTER       = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic               clk,
    input  logic               arstn,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wr_data,
    output logic               wr_full,
    output logic               wr_afull,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_empty,
    output logic               rd_aempty,
    output logic [POINTER:0]   level,
    output logic               overflow,
    output logic               underflow
);

    localparam int               DEPTH    = 2 ** POINTER;
    localparam logic [POINTER:0] DEPTH_L  = (POINTER + 1)'(DEPTH);
    localparam logic [POINTER:0] AFULL_L  = (POINTER + 1)'(AFULL_THRESH);
    localparam logic [POINTER:0] AEMPTY_L = (POINTER + 1)'(AEMPTY_THRESH);
    localparam logic [POINTER:0] ONE_L    = (POINTER + 1)'(1);
    localparam logic [POINTER:0] ZERO_L   = {(POINTER + 1){1'b0}};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [POINTER:0] wr_ptr_r;
    logic [POINTER:0] rd_ptr_r;
    logic [POINTER:0] level_r;
    logic [POINTER:0] level_nxt_s;
    logic             full_r;
    logic             afull_r;
    logic             empty_r;
    logic             aempty_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic [WIDTH-1:0] head_s;

    assign head_s = mem_r[rd_ptr_r[POINTER-1:0]];

    // Accept decode; flush suppresses both sides in its cycle.
    always_comb begin
        wr_acc_s = 1'b0;
        rd_acc_s = 1'b0;
        if (flush) begin
            wr_acc_s = 1'b0;
            rd_acc_s = 1'b0;
        end else begin
            wr_acc_s = wr_en & ~full_r;
            rd_acc_s = rd_en & ~empty_r;
        end
    end

    // Next occupancy; simultaneous accepts cancel out.
    always_comb begin
        level_nxt_s = level_r;
        if (flush) begin
            level_nxt_s = ZERO_L;
        end else begin
            case ({wr_acc_s, rd_acc_s})
                2'b10:   level_nxt_s = level_r + ONE_L;
                2'b01:   level_nxt_s = level_r - ONE_L;
                default: level_nxt_s = level_r;
            endcase
        end
    end

    // Read/write pointers, one wrap bit above the address.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr_r <= ZERO_L;
            rd_ptr_r <= ZERO_L;
        end else if (flush) begin
            wr_ptr_r <= ZERO_L;
            rd_ptr_r <= ZERO_L;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_L;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_L;
            end
        end
    end

    // Level and status flags, registered from the next level so they track level_r exactly.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            level_r  <= ZERO_L;
            full_r   <= 1'b0;
            afull_r  <= 1'b0;
            empty_r  <= 1'b1;
            aempty_r <= 1'b1;
        end else begin
            level_r  <= level_nxt_s;
            full_r   <= (level_nxt_s == DEPTH_L);
            afull_r  <= (level_nxt_s >= AFULL_L);
            empty_r  <= (level_nxt_s == ZERO_L);
            aempty_r <= (level_nxt_s <= AEMPTY_L);
        end
    end

    // Sticky error flags, cleared only by reset or flush.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (flush) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r  | (wr_en & full_r);
            underflow_r <= underflow_r | (rd_en & empty_r);
        end
    end

    // Storage array; contents deliberately survive reset and flush.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r[POINTER-1:0]] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data = empty_r ? {WIDTH{1'b0}} : head_s;
`else
    logic [WIDTH-1:0] rd_data_r;

    // Registered read port: head word captured on the popping edge, held otherwise.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (flush) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (rd_acc_s) begin
            rd_data_r <= head_s;
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;
`endif

    assign wr_full   = full_r;
    assign wr_afull  = afull_r;
    assign rd_empty  = empty_r;
    assign rd_aempty = aempty_r;
    assign level     = level_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo (DEPTH=16, AFULL=12, AEMPTY=2).
`timescale 1ns/1ps
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       arstn;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_full;
    logic       wr_afull;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_empty;
    logic       rd_aempty;
    logic [4:0] level;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_pass   = 0;

    sync_fifo #(
        .WIDTH(8), .POINTER(4), .AFULL_THRESH(12), .AEMPTY_THRESH(2)
    ) dut (
        .clk(clk), .arstn(arstn), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .wr_afull(wr_afull),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .rd_aempty(rd_aempty),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arstn = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        repeat (3) tick();
        arstn = 1'b1;
        repeat (10) tick();
        check("rst_empty",     32'(rd_empty),  32'd1);
        check("rst_aempty",    32'(rd_aempty), 32'd1);
        check("rst_full",      32'(wr_full),   32'd0);
        check("rst_afull",     32'(wr_afull),  32'd0);
        check("rst_level",     32'(level),     32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_rd_data",   32'(rd_data),   32'd0);

`ifdef SYNC_FIFO_FWFT_EN
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        check("fwft_head",  32'(rd_data),  32'hA5);
        check("fwft_empty", 32'(rd_empty), 32'd0);
        wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        check("fwft_hold",  32'(rd_data), 32'hA5);
        check("fwft_lvl2",  32'(level),   32'd2);
        rd_en = 1'b1;
        tick();
        check("fwft_pop",   32'(rd_data), 32'h5A);
        check("fwft_lvl1",  32'(level),   32'd1);
        tick();
        rd_en = 1'b0;
        check("fwft_drain", 32'(rd_data),  32'd0);
        check("fwft_mt",    32'(rd_empty), 32'd1);
`else
        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            check("fill_level", 32'(level),    32'(i + 1));
            check("fill_afull", 32'(wr_afull), (i + 1 >= 12) ? 32'd1 : 32'd0);
            check("fill_full",  32'(wr_full),  (i + 1 == 16) ? 32'd1 : 32'd0);
            check("fill_empty", 32'(rd_empty), 32'd0);
        end
        // Write while full
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        check("ovf_set",   32'(overflow), 32'd1);
        check("ovf_level", 32'(level),    32'd16);
        tick();
        check("ovf_sticky", 32'(overflow), 32'd1);
        // Drain, expecting 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            check("drain_data",   32'(rd_data),   32'(i));
            check("drain_level",  32'(level),     32'(15 - i));
            check("drain_aempty", 32'(rd_aempty), (15 - i <= 2) ? 32'd1 : 32'd0);
            check("drain_empty",  32'(rd_empty),  (i == 15) ? 32'd1 : 32'd0);
        end
        // Read while empty
        tick();
        rd_en = 1'b0;
        check("udf_set",   32'(underflow), 32'd1);
        check("udf_data",  32'(rd_data),   32'h0F);
        check("udf_level", 32'(level),     32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ovf",  32'(overflow),  32'd0);
        check("flush_udf",  32'(underflow), 32'd0);
        check("flush_data", 32'(rd_data),   32'd0);
        // Level 8 then streaming across the pointer wrap
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h48 + i);
            tick();
            check("stream_data",  32'(rd_data), 32'(8'h40 + i));
            check("stream_level", 32'(level),   32'd8);
        end
        rd_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h5C + i);
            tick();
        end
        check("refill_full", 32'(wr_full), 32'd1);
        // Full with simultaneous write and read
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        check("fullrw_level", 32'(level),    32'd15);
        check("fullrw_ovf",   32'(overflow), 32'd1);
        check("fullrw_data",  32'(rd_data),  32'h54);
        for (int i = 0; i < 15; i++) begin
            rd_en = 1'b1;
            tick();
            check("fullrw_drain", 32'(rd_data), 32'(8'h55 + i));
        end
        rd_en = 1'b0;
        check("fullrw_empty", 32'(rd_empty), 32'd1);
        // Flush beats a write in the same cycle
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h70 + i);
            tick();
        end
        check("pre_flush_level", 32'(level),    32'd5);
        check("pre_flush_ovf",   32'(overflow), 32'd1);
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        check("flush2_level", 32'(level),    32'd0);
        check("flush2_empty", 32'(rd_empty), 32'd1);
        check("flush2_ovf",   32'(overflow), 32'd0);
        check("flush2_data",  32'(rd_data),  32'd0);
        tick();
        check("flush2_nowr", 32'(level), 32'd0);
        // Empty with simultaneous write and read
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h33;
        tick();
        wr_en = 1'b0;
        check("mtrw_level", 32'(level),     32'd1);
        check("mtrw_udf",   32'(underflow), 32'd1);
        check("mtrw_data",  32'(rd_data),   32'd0);
        tick();
        rd_en = 1'b0;
        check("mtrw_read",  32'(rd_data), 32'h33);
        check("mtrw_level0", 32'(level),  32'd0);
        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h80 + i);
            tick();
        end
        rd_en = 1'b1; wr_data = 8'h83;
        tick();
        check("pre_rst_level", 32'(level), 32'd3);
        arstn = 1'b0;
        #1;
        check("arst_level", 32'(level),     32'd0);
        check("arst_empty", 32'(rd_empty),  32'd1);
        check("arst_afull", 32'(wr_afull),  32'd0);
        check("arst_data",  32'(rd_data),   32'd0);
        check("arst_udf",   32'(underflow), 32'd0);
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        arstn = 1'b1;
        tick();
        check("post_rst_level", 32'(level), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
